alu_multicycle: RTL and testbench

Datapath ALU that sits directly downstream of the ALU control decoder: it consumes the 4-bit `alu_control` code and two operands and produces a registered result with a start/done handshake. AND, OR, ADD, SUB and SLT complete in one cycle. DIV runs as an iterative signed restoring divider that produces a quotient and a remainder. The control unit stalls the PC while `busy` is high.

---
 rtl/alu_multicycle.sv | 168 ++++++++++++++++
 tb/tb_alu_multicycle.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle AND/OR/ADD/SUB/SLT and an optional iterative signed
// restoring divider, enabled by defining ALU_DIV_EN (absent: code 1010 is undefined).
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_DIV = 4'b1010;

  function automatic logic [WIDTH-1:0] alu_op(input logic [3:0] op,
                                              input logic signed [WIDTH-1:0] x,
                                              input logic signed [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (op)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, (x < y)};
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] op_res;
  assign op_res = alu_op(alu_control, a, b);

`ifdef ALU_DIV_EN
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIN} state_t;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_p, quo_p, dvs_p;
  logic             neg_q, neg_r;
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] rem_nxt, quo_nxt, quo_fin, rem_fin;
  logic             load;

  assign load = (state != S_DIV) && start && (alu_control == OP_DIV) && (b != '0);

  // One restoring step: remainder stays below the divisor, so the borrow bit decides.
  always_comb begin
    shifted = {rem_p, quo_p[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_p};
    if (diff[WIDTH]) begin
      rem_nxt = shifted[WIDTH-1:0];
      quo_nxt = {quo_p[WIDTH-2:0], 1'b0};
    end else begin
      rem_nxt = diff[WIDTH-1:0];
      quo_nxt = {quo_p[WIDTH-2:0], 1'b1};
    end
    quo_fin = apply_sign(quo_nxt, neg_q);
    rem_fin = apply_sign(rem_nxt, neg_r);
  end

  always_ff @(posedge clk) begin
    if (load) begin
      rem_p <= '0;
      quo_p <= magnitude(a);
      dvs_p <= magnitude(b);
      neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
      neg_r <= a[WIDTH-1];
    end else if (state == S_DIV) begin
      rem_p <= rem_nxt;
      quo_p <= quo_nxt;
    end
  end

  // FIN is the done cycle; it accepts a new start exactly like IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      result      <= '0;
      remainder   <= '0;
      zero        <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_DIV: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            result      <= quo_fin;
            remainder   <= rem_fin;
            zero        <= (quo_fin == '0);
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= S_FIN;
          end
        end
        default: begin
          state <= S_IDLE;
          if (start) begin
            if (alu_control == OP_DIV) begin
              if (b == '0) begin
                result      <= '1;
                remainder   <= a;
                zero        <= 1'b0;
                div_by_zero <= 1'b1;
                done        <= 1'b1;
              end else begin
                cnt   <= CW'(WIDTH - 1);
                busy  <= 1'b1;
                state <= S_DIV;
              end
            end else begin
              result      <= op_res;
              zero        <= (op_res == '0);
              div_by_zero <= 1'b0;
              done        <= 1'b1;
            end
          end
        end
      endcase
    end
  end
`else
  assign remainder   = '0;
  assign busy        = 1'b0;
  assign div_by_zero = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= '0;
      zero   <= 1'b1;
      done   <= 1'b0;
    end else begin
      done <= start;
      if (start) begin
        result <= op_res;
        zero   <= (op_res == '0);
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle; expectations follow ALU_DIV_EN when it is defined.
module tb_alu_multicycle;

  localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110, SLT = 4'b0111;
  localparam logic [3:0] AND_ = 4'b0000, DIV = 4'b1010, UND = 4'b1111;
`ifdef ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  alu;
  logic [31:0] a, b, result, remainder;
  logic        zero, busy, done, div_by_zero;

  typedef struct {
    logic [31:0] res;
    logic [31:0] rem;
    logic        z;
    logic        dbz;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_control(alu), .a(a), .b(b),
    .result(result), .remainder(remainder), .zero(zero), .busy(busy),
    .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] res, input logic [31:0] rem,
                          input logic z, input logic dbz);
    exp_t e;
    e.res = res; e.rem = rem; e.z = z; e.dbz = dbz;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      exp_t e;
      done_cnt++;
      if (q.size() == 0) begin
        chk("unexpected_done", result, 32'hDEAD_BEEF ^ result ^ 32'h1);
      end else begin
        e = q.pop_front();
        chk("result", result, e.res);
        chk("remainder", remainder, e.rem);
        chk("zero", 32'(zero), 32'(e.z));
        chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
      end
    end
  end

  task automatic drive_start(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    alu = op; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    a = $urandom; b = $urandom; alu = 4'($urandom);
  endtask

  task automatic wait_done(input int d0, input int bound);
    for (int i = 0; i < bound && done_cnt == d0; i++) @(negedge clk);
    #1 chk("done_timeout", 32'(done_cnt != d0), 32'd1);
  endtask

  task automatic run(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] res, input logic [31:0] rem, input logic z,
                     input logic dbz);
    int d0;
    d0 = done_cnt;
    push_exp(res, rem, z, dbz);
    drive_start(op, x, y);
    wait_done(d0, 40);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_result"}, result, 32'd0);
    chk({tag, "_remainder"}, remainder, 32'd0);
    chk({tag, "_ctl"}, {28'd0, zero, busy, done, div_by_zero}, 32'b1000);
  endtask

  initial begin
    int bad;
    int d0;
    reset = 1'b1; start = 1'b0; alu = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;

    // ADD with exact one-cycle latency
    d0 = done_cnt;
    push_exp(32'd12, 32'd0, 1'b0, 1'b0);
    drive_start(ADD, 32'd5, 32'd7);
    @(negedge clk);
    chk("add_done_c1", {30'd0, done, busy}, 32'b10);
    wait_done(d0, 5);

    run(SUB, 32'd9, 32'd9, 32'd0, 32'd0, 1'b1, 1'b0);
    run(SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0);
    run(AND_, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 32'd0, 1'b0, 1'b0);
    run(UND, 32'h1234_5678, 32'h1, 32'd0, 32'd0, 1'b1, 1'b0);

    // DIV 100/7 with busy window
    d0 = done_cnt;
    push_exp(DIV_EN ? 32'd14 : 32'd0, DIV_EN ? 32'd2 : 32'd0, !DIV_EN, 1'b0);
    drive_start(DIV, 32'd100, 32'd7);
`ifdef ALU_DIV_EN
    bad = 0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (!busy || done) bad++;
    end
    chk("div_busy_window", 32'(bad), 32'd0);
    @(negedge clk);
    chk("div_done_c33", {30'd0, done, busy}, 32'b10);
`else
    @(negedge clk);
    chk("nodiv_done_c1", {30'd0, done, busy}, 32'b10);
`endif
    wait_done(d0, 5);

    run(DIV, 32'hFFFF_FFF9, 32'd2, DIV_EN ? 32'hFFFF_FFFD : 32'd0,
        DIV_EN ? 32'hFFFF_FFFF : 32'd0, !DIV_EN, 1'b0);
    run(DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_EN ? 32'h8000_0000 : 32'd0,
        32'd0, !DIV_EN, 1'b0);

    // Divide by zero completes in one cycle
    d0 = done_cnt;
    push_exp(DIV_EN ? 32'hFFFF_FFFF : 32'd0, DIV_EN ? 32'd5 : 32'd0, !DIV_EN, DIV_EN);
    drive_start(DIV, 32'd5, 32'd0);
    @(negedge clk);
    chk("dbz_done_c1", {30'd0, done, busy}, 32'b10);
    wait_done(d0, 5);
    run(ADD, 32'd1, 32'd2, 32'd3, DIV_EN ? 32'd5 : 32'd0, 1'b0, 1'b0);

`ifdef ALU_DIV_EN
    // start while busy is ignored; start in the done cycle is accepted
    push_exp(32'd14, 32'd2, 1'b0, 1'b0);
    drive_start(DIV, 32'd100, 32'd7);
    for (int k = 1; k <= 4; k++) @(negedge clk);
    @(negedge clk);
    alu = ADD; a = 32'd1; b = 32'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 6; k <= 33; k++) @(negedge clk);
    chk("div_ignore_done33", 32'(done), 32'd1);
    push_exp(32'd7, 32'd2, 1'b0, 1'b0);
    alu = ADD; a = 32'd3; b = 32'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("b2b_done", 32'(done), 32'd1);

    // Reset in the middle of a division
    drive_start(DIV, 32'd100, 32'd7);
    for (int k = 1; k <= 10; k++) @(negedge clk);
    reset = 1'b1;
    #1 chk_reset_vals("midreset");
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) bad++;
    end
    chk("midreset_no_done", 32'(bad), 32'd0);
`endif

    run(ADD, 32'd1, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
